// File: rtl/fifo_rd_stream_if.sv
// Read-side FIFO port plus downstream valid/ready stream seen by fifo_rd_stream.
// master: the adapter (drives o_*); slave: FIFO/consumer side (drives i_*).
interface fifo_rd_stream_if #(
    parameter int Width = 8
);
    logic             o_rd_en;
    logic [Width-1:0] i_rd_data;
    logic             i_empty;
    logic             o_valid;
    logic [Width-1:0] o_data;
    logic             i_ready;

    modport master (
        output o_rd_en,
        output o_valid,
        output o_data,
        input  i_rd_data,
        input  i_empty,
        input  i_ready
    );

    modport slave (
        input  o_rd_en,
        input  o_valid,
        input  o_data,
        output i_rd_data,
        output i_empty,
        output i_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a registered-read FIFO into a valid/ready stream via a head+skid buffer.
// Optional accepted-word counter o_count enabled by macro FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
    parameter int Width    = 8,
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_rd_stream_if.master    bus
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CntWidth-1:0] o_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t             state_reg;
    logic [Width-1:0] head_reg;
    logic [Width-1:0] skid_reg;
    logic             inflight_reg;
    logic             valid_reg;

    logic       pop;
    logic [1:0] occ;
    logic [2:0] level_after_pop;

    always_comb begin
        occ = 2'd0;
        case (state_reg)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    assign pop = valid_reg && bus.i_ready;

    // Words that will still be held or arriving after this cycle's pop; a new
    // read may only be issued while that leaves room for its capture.
    assign level_after_pop = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};
    assign bus.o_rd_en     = rst_n && !bus.i_empty && (level_after_pop < 3'd2);

    assign bus.o_valid = valid_reg;
    assign bus.o_data  = head_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            head_reg     <= '0;
            skid_reg     <= '0;
            inflight_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            inflight_reg <= bus.o_rd_en;
            case (state_reg)
                EMPTY: begin
                    if (inflight_reg) begin
                        head_reg  <= bus.i_rd_data;
                        valid_reg <= 1'b1;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    case ({pop, inflight_reg})
                        2'b01: begin
                            skid_reg  <= bus.i_rd_data;
                            state_reg <= TWO;
                        end
                        2'b10: begin
                            valid_reg <= 1'b0;
                            state_reg <= EMPTY;
                        end
                        2'b11: begin
                            head_reg <= bus.i_rd_data;
                        end
                        default: ;
                    endcase
                end
                TWO: begin
                    // The issue rule keeps captures out of TWO, so only a pop moves us.
                    if (pop) begin
                        head_reg  <= skid_reg;
                        state_reg <= ONE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= EMPTY;
                end
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CntWidth-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (pop) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign o_count = count_reg;
`else
    if (CntWidth < 1) begin : g_cnt_width_check
        $error("fifo_rd_stream: CntWidth must be at least 1");
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised and directed bench for fifo_rd_stream against a queue-based FIFO/stream model.
module tb_fifo_rd_stream;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.Width(W)) bus ();

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CW-1:0] o_count;
`endif

    fifo_rd_stream #(
        .Width    (W),
        .CntWidth (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .o_count (o_count)
`endif
    );

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           inflight_m;
    int           count_m;
    int           total;
    int           bad;
    int           cyc;
    bit           prev_hold;
    logic [W-1:0] prev_data;
    int           rd_cnt, valid_cnt, acc_cnt;
    int           first_rd, first_valid, first_acc, last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_trackers();
        rd_cnt = 0; valid_cnt = 0; acc_cnt = 0;
        first_rd = -1; first_valid = -1; first_acc = -1; last_acc = -1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        exp_q.delete();
        inflight_m = 0;
        count_m    = 0;
        prev_hold  = 1'b0;
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit           ev, ep, er;
        int           avail;
        logic [W-1:0] w;
        bus.i_empty = (fifo_q.size() == 0);
        @(negedge clk);
        avail = exp_q.size() - inflight_m;
        ev = (rst_n === 1'b1) && (avail > 0);
        ep = ev && bus.i_ready;
        er = (rst_n === 1'b1) && !bus.i_empty && ((exp_q.size() - int'(ep)) < 2);
        chk("valid", 32'(bus.o_valid), 32'(ev));
        if (ev) chk("data", 32'(bus.o_data), 32'(exp_q[0]));
        else if (rst_n !== 1'b1) chk("rst_data", 32'(bus.o_data), 32'(0));
        chk("rd_en", 32'(bus.o_rd_en), 32'(er));
        if (prev_hold) chk("hold_data", 32'(bus.o_data), 32'(prev_data));
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("count", 32'(o_count), 32'(count_m));
`endif
        if (bus.o_rd_en === 1'b1) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.o_valid === 1'b1) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            if (bus.i_ready) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
        end
        prev_hold = ev && !bus.i_ready;
        prev_data = bus.o_data;
        @(posedge clk);
        #1;
        cyc++;
        if (ep) begin
            void'(exp_q.pop_front());
            count_m = (count_m + 1) % (1 << CW);
        end
        inflight_m = int'(er);
        if (er) begin
            w = fifo_q.pop_front();
            bus.i_rd_data = w;
            exp_q.push_back(w);
        end else begin
            bus.i_rd_data = 8'($urandom);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        inflight_m = 0; count_m = 0; prev_hold = 1'b0; prev_data = '0;
        clear_trackers();
        rst_n         = 1'b0;
        bus.i_ready   = 1'b1;
        bus.i_empty   = 1'b1;
        bus.i_rd_data = '0;

        // Reset held with FIFO non-empty: no reads, no valid, zero data
        for (int i = 0; i < 3; i++) fifo_q.push_back(8'(8'h30 + i));
        #1;
        repeat (3) cycle();
        rst_n = 1'b1;
        clear_trackers();
        cycle();
        chk("first_rd_after_reset", 32'(rd_cnt), 32'(1));
        repeat (6) cycle();

        // Single word
        clear_trackers();
        fifo_q.push_back(8'hA5);
        repeat (6) cycle();
        chk("single_rd_cnt", 32'(rd_cnt), 32'(1));
        chk("single_valid_cnt", 32'(valid_cnt), 32'(1));
        chk("single_latency", 32'(first_valid - first_rd), 32'(2));

        // Streaming 0x00..0x0F without gaps
        clear_trackers();
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        repeat (22) cycle();
        chk("stream_words", 32'(acc_cnt), 32'(16));
        chk("stream_span", 32'(last_acc - first_acc), 32'(15));

        // Backpressure mid-stream
        for (int i = 0; i < 20; i++) fifo_q.push_back(8'($urandom));
        repeat (4) cycle();
        bus.i_ready = 1'b0;
        repeat (5) cycle();
        chk("bp_rd_en_stopped", 32'(bus.o_rd_en), 32'(0));
        chk("bp_valid_held", 32'(bus.o_valid), 32'(1));
        bus.i_ready = 1'b1;
        repeat (25) cycle();

        // Random pushes and random backpressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
            bus.i_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.i_ready = 1'b1;
        repeat (12) cycle();
        chk("drained_valid", 32'(bus.o_valid), 32'(0));

        // Reset pulsed while buffer is full
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'hC0 + i));
        bus.i_ready = 1'b0;
        repeat (6) cycle();
        chk("two_before_reset", 32'(bus.o_valid), 32'(1));
        assert_reset();
        #1;
        chk("rst_valid_now", 32'(bus.o_valid), 32'(0));
        chk("rst_data_now", 32'(bus.o_data), 32'(0));
        chk("rst_rd_en_now", 32'(bus.o_rd_en), 32'(0));
        repeat (2) cycle();
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        repeat (12) cycle();

        // 17 pops after reset wrap a 4-bit counter to 1
        assert_reset();
        cycle();
        rst_n = 1'b1;
        clear_trackers();
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'($urandom));
        repeat (25) cycle();
        chk("pops_17", 32'(acc_cnt), 32'(17));
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("count_wrap", 32'(o_count), 32'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
